// File: rtl/math_mult_pkg.sv
// Shared widths and a plain reference product for the carry-save multiplier.
// The optional MATH_MULT_CS_PIPE_IN_EN build is handled in the top module.
package math_mult_pkg;

  localparam int unsigned N_DEFAULT = 4;

  function automatic int unsigned prod_w(
    input int unsigned n
  );
    return 2 * n + 1;
  endfunction

  function automatic logic [63:0] ref_mult(
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [63:0] xe;
    logic [63:0] ye;
    xe = {32'd0, x};
    ye = {32'd0, y};
    return xe * ye;
  endfunction

endpackage

// File: rtl/csa_full_adder.sv
// One-bit full adder cell used by the carry-save array and the merge row.
// Half-adder positions are built by tying cin low.
module csa_full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic xy;

  assign xy   = x ^ y;
  assign s    = xy ^ cin;
  assign cout = (x & y) | (cin & xy);

endmodule

// File: rtl/math_multiplier_carry_save.sv
// Unsigned NxN carry-save array multiplier with a ripple merge and registered product.
// Define MATH_MULT_CS_PIPE_IN_EN to register a/b/in_valid first (2-cycle latency).
module math_multiplier_carry_save
  import math_mult_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [N-1:0]           a,
  input  logic [N-1:0]           b,
  output logic                   out_valid,
  output logic [prod_w(N)-1:0]   p
);

  localparam int PW = prod_w(N);

  logic [N-1:0] a_m;
  logic [N-1:0] b_m;
  logic         v_m;

`ifdef MATH_MULT_CS_PIPE_IN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      a_m <= '0;
      b_m <= '0;
      v_m <= 1'b0;
    end else begin
      a_m <= a;
      b_m <= b;
      v_m <= in_valid;
    end
  end
`else
  assign a_m = a;
  assign b_m = b;
  assign v_m = in_valid;
`endif

  logic [N-1:0] pp [N];
  logic [N-1:0] lo;
  logic [N-1:0] hi;
  logic         top;
  logic [PW-1:0] prod;

  genvar i;
  genvar j;

  for (i = 0; i < N; i++) begin : g_pp
    assign pp[i] = a_m & {N{b_m[i]}};
  end

  // Row i, cell j carries weight 2^(i+j); carries drop straight down a column.
  for (i = 0; i < N; i++) begin : g_row
    logic [N-1:0] s;
    logic [N-1:0] c;

    if (i == 0) begin : g_seed
      assign s = pp[0];
      assign c = '0;
    end else begin : g_csa
      for (j = 0; j < N; j++) begin : g_cell
        logic y;

        if (j == N - 1) begin : g_edge
          assign y = 1'b0;
        end else begin : g_mid
          assign y = g_row[i-1].s[j+1];
        end

        csa_full_adder u_fa (
          .x    (pp[i][j]),
          .y    (y),
          .cin  (g_row[i-1].c[j]),
          .s    (s[j]),
          .cout (c[j])
        );
      end
    end

    assign lo[i] = s[0];
  end

  for (j = 0; j < N; j++) begin : g_merge
    logic y;
    logic ci;
    logic co;

    if (j == N - 1) begin : g_edge
      assign y = 1'b0;
    end else begin : g_mid
      assign y = g_row[N-1].s[j+1];
    end

    if (j == 0) begin : g_lsb
      assign ci = 1'b0;
    end else begin : g_chain
      assign ci = g_merge[j-1].co;
    end

    csa_full_adder u_fa (
      .x    (g_row[N-1].c[j]),
      .y    (y),
      .cin  (ci),
      .s    (hi[j]),
      .cout (co)
    );
  end

  // The merge carry-out is arithmetically zero; it fills the spare top bit.
  assign top  = g_merge[N-1].co;
  assign prod = {top, hi, lo};

  always_ff @(posedge clk) begin
    if (rst) begin
      p         <= '0;
      out_valid <= 1'b0;
    end else begin
      p         <= prod;
      out_valid <= v_m;
    end
  end

endmodule

// File: tb/tb_math_multiplier_carry_save.sv
// Randomized self-checking bench for math_multiplier_carry_save.
// Expected values come from a queue model of plain products.
module tb_math_multiplier_carry_save;
  import math_mult_pkg::*;

  localparam int N  = 4;
  localparam int PW = 2 * N + 1;
  localparam int W8 = 8;
  localparam int P8 = 2 * W8 + 1;
`ifdef MATH_MULT_CS_PIPE_IN_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic          v;
    logic [PW-1:0] p;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          out_valid;
  logic [PW-1:0] p;

  logic          v8;
  logic [W8-1:0] a8;
  logic [W8-1:0] b8;
  logic          ov8;
  logic [P8-1:0] p8;

  int checks;
  int failures;
  exp_t q[$];

  math_multiplier_carry_save #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .p         (p)
  );

  math_multiplier_carry_save #(.N(W8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v8),
    .a         (a8),
    .b         (b8),
    .out_valid (ov8),
    .p         (p8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle, advance past the edge, and report the model's expectation.
  task automatic tick(
    input  logic          r,
    input  logic          v,
    input  logic [N-1:0]  x,
    input  logic [N-1:0]  y,
    output logic          ok,
    output logic          ev,
    output logic [PW-1:0] ep
  );
    exp_t e;
    logic [63:0] m;
    rst      = r;
    in_valid = v;
    a        = x;
    b        = y;
    m = ref_mult(32'(x), 32'(y));
    if (r) begin
      e.v = 1'b0;
      e.p = '0;
    end else begin
      e.v = v;
      e.p = m[PW-1:0];
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    ok = !r && (q.size() >= LAT);
    ev = 1'b0;
    ep = '0;
    if (ok) begin
      ev = q[q.size()-LAT].v;
      ep = q[q.size()-LAT].p;
    end
    if (q.size() > 8) void'(q.pop_front());
  endtask

  task automatic test_reset();
    logic ok, ev;
    logic [PW-1:0] ep;
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 1'b1, 4'd13, 4'd13, ok, ev, ep);
      checks++;
      if (p !== '0 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: got v=%0b p=%0d, want v=0 p=0",
                 out_valid, p);
      end
    end
    for (int k = 0; k < LAT; k++) begin
      tick(1'b0, 1'b1, 4'd13, 4'd13, ok, ev, ep);
      if (ok) begin
        checks++;
        if (out_valid !== ev || p !== ep) begin
          failures++;
          $display("FAIL reset_release: got v=%0b p=%0d, want v=%0b p=%0d",
                   out_valid, p, ev, ep);
        end
      end
    end
    checks++;
    if (p !== 9'h0A9 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_first: got v=%0b p=%0d, want v=1 p=169",
               out_valid, p);
    end
  endtask

  task automatic test_truncated();
    logic ok, ev;
    logic [PW-1:0] ep;
    logic [15:0] wa;
    logic [15:0] wb;
    wa = 16'hF00D;
    wb = 16'h0DAD;
    for (int k = 0; k < LAT; k++) begin
      if (k == 0) tick(1'b0, 1'b1, wa[N-1:0], wb[N-1:0], ok, ev, ep);
      else        tick(1'b0, 1'b0, 4'd0, 4'd0, ok, ev, ep);
    end
    checks++;
    if (p !== 9'd169 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL truncated: got v=%0b p=%0d, want v=1 p=169",
               out_valid, p);
    end
  endtask

  task automatic test_exhaustive();
    logic ok, ev;
    logic [PW-1:0] ep;
    for (int t = 0; t < (1 << (2 * N)) + LAT; t++) begin
      if (t < (1 << (2 * N)))
        tick(1'b0, 1'b1, N'(t >> N), N'(t), ok, ev, ep);
      else
        tick(1'b0, 1'b0, '0, '0, ok, ev, ep);
      if (ok) begin
        checks++;
        if (out_valid !== ev || p !== ep || p[PW-1] !== 1'b0) begin
          failures++;
          $display("FAIL exhaustive: got v=%0b p=%0d, want v=%0b p=%0d",
                   out_valid, p, ev, ep);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic ok, ev;
    logic [PW-1:0] ep;
    logic [N-1:0] xs [3];
    logic [N-1:0] ys [3];
    int seq [3];
    xs  = '{4'd15, 4'd0, 4'd1};
    ys  = '{4'd15, 4'd0, 4'd15};
    seq = '{225, 0, 15};
    for (int t = 0; t < 3 + LAT - 1; t++) begin
      if (t < 3) tick(1'b0, 1'b1, xs[t], ys[t], ok, ev, ep);
      else       tick(1'b0, 1'b0, 4'd7, 4'd9, ok, ev, ep);
      if (t >= LAT - 1) begin
        checks++;
        if (out_valid !== 1'b1 || p !== PW'(seq[t-LAT+1])) begin
          failures++;
          $display("FAIL back_to_back: got v=%0b p=%0d, want v=1 p=%0d",
                   out_valid, p, seq[t-LAT+1]);
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic ok, ev;
    logic [PW-1:0] ep;
    logic vs [3];
    vs = '{1'b1, 1'b0, 1'b1};
    for (int t = 0; t < 3 + LAT; t++) begin
      tick(1'b0, (t < 3) ? vs[t] : 1'b0, N'($urandom), N'($urandom),
           ok, ev, ep);
      if (ok) begin
        checks++;
        if (out_valid !== ev || p !== ep) begin
          failures++;
          $display("FAIL gaps: got v=%0b p=%0d, want v=%0b p=%0d",
                   out_valid, p, ev, ep);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic ok, ev;
    logic [PW-1:0] ep;
    for (int t = 0; t < 6 + LAT; t++) begin
      tick(t == 2, t != 3, N'($urandom_range(1, 15)),
           N'($urandom_range(1, 15)), ok, ev, ep);
      checks++;
      if (t == 2) begin
        if (out_valid !== 1'b0 || p !== '0) begin
          failures++;
          $display("FAIL midstream_rst: got v=%0b p=%0d, want v=0 p=0",
                   out_valid, p);
        end
      end else if (out_valid !== ev || p !== ep) begin
        failures++;
        $display("FAIL midstream: got v=%0b p=%0d, want v=%0b p=%0d",
                 out_valid, p, ev, ep);
      end
    end
  endtask

  task automatic test_random();
    logic ok, ev;
    logic [PW-1:0] ep;
    for (int t = 0; t < 200; t++) begin
      tick(1'b0, 1'($urandom), N'($urandom), N'($urandom), ok, ev, ep);
      if (ok) begin
        checks++;
        if (out_valid !== ev || p !== ep) begin
          failures++;
          $display("FAIL random: got v=%0b p=%0d, want v=%0b p=%0d",
                   out_valid, p, ev, ep);
        end
      end
    end
  endtask

  task automatic test_wide_corners();
    logic ok, ev;
    logic [PW-1:0] ep;
    logic [W8-1:0] xs [6];
    logic [W8-1:0] ys [6];
    logic [63:0] m;
    xs = '{8'd255, 8'd128, 8'd0, 8'd1, 8'($urandom), 8'($urandom)};
    ys = '{8'd255, 8'd2, 8'd255, 8'd1, 8'($urandom), 8'($urandom)};
    for (int k = 0; k < 6; k++) begin
      a8 = xs[k];
      b8 = ys[k];
      v8 = 1'b1;
      m = ref_mult(32'(xs[k]), 32'(ys[k]));
      for (int c = 0; c < LAT; c++)
        tick(1'b0, 1'b0, '0, '0, ok, ev, ep);
      checks++;
      if (ov8 !== 1'b1 || p8 !== m[P8-1:0]) begin
        failures++;
        $display("FAIL wide_corner: got v=%0b p=%0d, want v=1 p=%0d",
                 ov8, p8, m[P8-1:0]);
      end
    end
    v8 = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    v8       = 1'b0;
    a8       = '0;
    b8       = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_truncated();
    test_exhaustive();
    test_back_to_back();
    test_gaps();
    test_reset_midstream();
    test_random();
    test_wide_corners();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/math_multiplier_carry_save.md
Name: math_multiplier_carry_save

Overview:
Unsigned N×N array multiplier built from a carry-save adder array with a final ripple-carry merge stage.
The result is registered, so the block presents a one-clock-latency product.
It is a generic arithmetic leaf used by datapath blocks that need a small, area-oriented, non-DSP multiplier.

Parameters:
N, 4, operand width in bits (N ≥ 2).

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  synchronous active-high reset.
in_valid  input  1  a/b qualify this cycle.
a  input  N  unsigned multiplicand.
b  input  N  unsigned multiplier.
out_valid  output  1  p holds the product of the pair accepted one cycle earlier.
p  output  2N+1  unsigned product. Bit 2N is always 0, kept for width compatibility.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: on a rising clk with rst=1, p <= 0 and out_valid <= 0. rst has priority over in_valid.
- Datapath:
  - Partial products pp[i][j] = a[j] & b[i].
  - Row 0 seeds the sum vector.
  - Rows 1..N-1 each use N full/half-adder cells. Each cell takes sum-in from the row above (shifted), carry-in from the same column of the previous row, and pp. No horizontal carry propagation inside a row.
  - Final row: N-bit ripple-carry adder merges the last sum and carry vectors into p[2N-1:N].
  - p[k] for k<N comes from the LSB sum of row k.
- Combinational result = a*b exactly, modulo nothing: the full 2N-bit product fits, and p[2N]=0.
- Latency: 1 cycle.
  - Every rising edge with rst=0: p <= a*b, out_valid <= in_valid.
  - p updates every cycle regardless of in_valid (no clock gating). Consumers must use out_valid.
- Throughput: one product per cycle, no backpressure.
- Boundary cases:
  - a=0 or b=0 gives 0.
  - a=b=2^N-1 gives (2^N-1)^2 with p[2N]=0.
- Reset mid-stream: the pending result is discarded. The first valid output comes one cycle after the first in_valid following rst release.

Optional Feature:
MATH_MULT_CS_PIPE_IN_EN
- Defined: a and b and in_valid are registered first; the array then operates on the registered values. Total latency is 2 cycles, and the input registers reset to 0.
- Undefined: latency is 1 cycle, as above.
- Either way the p value sequence is identical, only delayed.

Decomposition:
- Package math_mult_pkg: localparam helper for product width (2N+1) and a function ref_mult used by the testbench model.
- Sub-module csa_full_adder: 1-bit full adder with ports x, y, cin, s, cout. The array instantiates it N*(N-1) times plus the N merge cells. Half-adder positions tie cin to 0.

Test Plan:
- Reset: assert rst 2 cycles with a=13, b=13 -> p=0 and out_valid=0 throughout; release -> next edge p=169 (0x0A9).
- Truncated wide stimulus: a=0xF00D[3:0]=13, b=0x0DAD[3:0]=13, in_valid=1 -> one cycle later p=169, out_valid=1.
- Exhaustive N=4: all 256 (a,b) pairs, one per cycle -> each p equals a*b one cycle later and p[8]=0. Includes 15*15=225, 0*15=0, 1*1=1.
- Back-to-back streaming: alternate (15,15),(0,0),(1,15) -> p sequence 225, 0, 15 on consecutive cycles.
- in_valid gaps: in_valid=1,0,1 -> out_valid=1,0,1 one cycle later; p still tracks a*b every cycle.
- With MATH_MULT_CS_PIPE_IN_EN: repeat the exhaustive test -> results identical but 2-cycle latency; N=8 sweep of corners (255*255=65025, 128*2=256).
